layer_scheduler: RTL and testbench
==================================

LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, bits per colour channel.
REQ-002 Parameter NUM_LAYERS, default 4, number of layer sources; legal range 2..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  a pixel composite is requested.
REQ-006 req_ready  output  1  the scheduler can accept a request.
REQ-007 bg_r, bg_g, bg_b  input  DEPTH each  background colour, sampled on request accept.
REQ-008 layer_req  output  1  fetch strobe to the layer sources.
REQ-009 layer_sel  output  $clog2(NUM_LAYERS)  index of the layer being fetched.
REQ-010 layer_r, layer_g, layer_b  input  DEPTH each  fetched layer colour, valid the cycle after layer_req.
REQ-011 layer_a  input  1  fetched layer opaque flag, valid the cycle after layer_req.
REQ-012 out_valid  output  1  composite result is available.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_r, out_g, out_b  output  DEPTH each  composite colour.
REQ-015 out_a  output  1  set when any fetched layer was opaque.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, CAPTURE and DONE.
REQ-017 In IDLE, req_ready=1; req_valid=1 accepts a request, latches bg into the accumulator with A=0, sets k=NUM_LAYERS-1, and moves to ISSUE.
REQ-018 In ISSUE, layer_req=1 and layer_sel=k for exactly one cycle, then the FSM moves to CAPTURE; layer_req=0 in every other state.
REQ-019 In CAPTURE, if the accumulator A=0 and layer_a=1, the accumulator SHALL load layer_r/g/b with A=1; otherwise it holds, so the highest opaque layer wins.
REQ-020 Leaving CAPTURE: if k=0, go to DONE; else decrement k and go to ISSUE.
REQ-021 In DONE, out_valid=1 and out_* reflect the accumulator, stable until out_ready=1; then go to IDLE.
REQ-022 req_ready=0 outside IDLE; no new request is accepted in the DONE→IDLE transition cycle.
REQ-023 Latency with EARLY_EXIT_EN undefined: accept at cycle 0 gives out_valid at cycle 2*NUM_LAYERS+1.
REQ-024 Zero opaque layers SHALL yield out = bg colour with out_a=0.
REQ-025 layer_r/g/b/a are ignored outside CAPTURE.
REQ-026 Back-pressure SHALL be unlimited; out_ready=0 holds DONE indefinitely with no output change.

Reset
REQ-027 rst=1 on an edge forces IDLE, k=NUM_LAYERS-1, accumulator zero, out_valid=0, layer_req=0, layer_sel=0, out_*=0, req_ready=1 the next cycle.
REQ-028 Reset in any state SHALL abandon the in-flight composite with no out_valid pulse.
REQ-029 rst has priority over every handshake in the same cycle.

Configuration
REQ-030 Macro LAYER_SCHED_EARLY_EXIT_EN, when defined, makes CAPTURE with layer_a=1 go directly to DONE, skipping the remaining layers.
REQ-031 With the macro defined, the result SHALL equal the undefined case; only latency differs, ranging from 3 cycles (top layer opaque) to 2*NUM_LAYERS+1.
REQ-032 With the macro undefined, all NUM_LAYERS layers are always fetched.

Verification
REQ-033 NUM_LAYERS=4, bg=(1,2,3), all layer_a=0 -> layer_sel 3,2,1,0; out=(1,2,3), out_a=0, out_valid at cycle 9.
REQ-034 Layer 2 opaque (A,B,C), layer 0 opaque (5,5,5) -> out=(A,B,C), out_a=1; with the macro, out_valid at cycle 5 and layer_sel never 1 or 0.
REQ-035 Layer 3 opaque with the macro -> out_valid at cycle 3, exactly one layer_req pulse.
REQ-036 out_ready=0 for 10 cycles in DONE -> out_* stable, req_ready=0, req_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-037 rst asserted in CAPTURE of layer 1 -> next cycle IDLE, all outputs at reset values, no out_valid; a following request composites correctly.

Source files
------------

// File: rtl/layer_scheduler_if.sv
// layer_scheduler_if: request, layer-fetch and result signals of the layer compositor
interface layer_scheduler_if #(
  parameter int DEPTH = 4,
  parameter int NUM_LAYERS = 4
);
  localparam int SW = $clog2(NUM_LAYERS);
  logic req_valid;
  logic req_ready;
  logic [DEPTH-1:0] bg_r, bg_g, bg_b;
  logic layer_req;
  logic [SW-1:0] layer_sel;
  logic [DEPTH-1:0] layer_r, layer_g, layer_b;
  logic layer_a;
  logic out_valid;
  logic out_ready;
  logic [DEPTH-1:0] out_r, out_g, out_b;
  logic out_a;
  modport slave (
    input req_valid, bg_r, bg_g, bg_b, layer_r, layer_g, layer_b, layer_a, out_ready,
    output req_ready, layer_req, layer_sel, out_valid, out_r, out_g, out_b, out_a
  );
  modport master (
    output req_valid, bg_r, bg_g, bg_b, layer_r, layer_g, layer_b, layer_a, out_ready,
    input req_ready, layer_req, layer_sel, out_valid, out_r, out_g, out_b, out_a
  );
endinterface

// File: rtl/layer_scheduler.sv
// layer_scheduler: fetches layers top-down and keeps the highest opaque one over the background.
// Define LAYER_SCHED_EARLY_EXIT_EN to stop fetching at the first opaque layer.
module layer_scheduler #(
  parameter int DEPTH = 4,
  parameter int NUM_LAYERS = 4
) (
  input logic clk,
  input logic rst,
  layer_scheduler_if.slave bus
);
  localparam int SW = $clog2(NUM_LAYERS);
  localparam logic [SW-1:0] K_TOP = SW'(NUM_LAYERS - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
  state_t state;
  logic [SW-1:0] k, sel;
  logic [DEPTH-1:0] acc_r, acc_g, acc_b;
  logic acc_a, rdy, lreq, ovld, last;
`ifdef LAYER_SCHED_EARLY_EXIT_EN
  assign last = bus.layer_a || k == '0;
`else
  assign last = k == '0;
`endif
  assign bus.req_ready = rdy;
  assign bus.layer_req = lreq;
  assign bus.layer_sel = sel;
  assign bus.out_valid = ovld;
  assign bus.out_r = acc_r;
  assign bus.out_g = acc_g;
  assign bus.out_b = acc_b;
  assign bus.out_a = acc_a;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= K_TOP;
      {acc_r, acc_g, acc_b, acc_a} <= '0;
      rdy <= 1'b1;
      lreq <= 1'b0;
      sel <= '0;
      ovld <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          {acc_r, acc_g, acc_b, acc_a} <= {bus.bg_r, bus.bg_g, bus.bg_b, 1'b0};
          k <= K_TOP;
          sel <= K_TOP;
          lreq <= 1'b1;
          rdy <= 1'b0;
          state <= ISSUE;
        end
        ISSUE: begin
          lreq <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          // first opaque layer seen from the top owns the pixel
          if (!acc_a && bus.layer_a)
            {acc_r, acc_g, acc_b, acc_a} <= {bus.layer_r, bus.layer_g, bus.layer_b, 1'b1};
          if (last) begin
            ovld <= 1'b1;
            state <= DONE;
          end else begin
            k <= k - SW'(1);
            sel <= k - SW'(1);
            lreq <= 1'b1;
            state <= ISSUE;
          end
        end
        DONE: if (bus.out_ready) begin
          ovld <= 1'b0;
          rdy <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_scheduler.sv
// tb_layer_scheduler: scoreboard bench for layer_scheduler with a behavioural layer source
module tb_layer_scheduler;
  localparam int D = 4;
  localparam int NL = 4;
  typedef struct packed {logic [D-1:0] r, g, b; logic a;} pix_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  layer_scheduler_if #(.DEPTH(D), .NUM_LAYERS(NL)) bus ();
  layer_scheduler #(.DEPTH(D), .NUM_LAYERS(NL)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  pix_t sb[$];
  int sel_log[$];
  logic [D-1:0] src_r[NL], src_g[NL], src_b[NL];
  logic src_a[NL];
  bit pend = 0;

  // layer source: answers a fetch with stable data through the capture cycle, junk otherwise
  always @(negedge clk) begin
    if (bus.layer_req) begin
      sel_log.push_back(int'(bus.layer_sel));
      bus.layer_r = src_r[bus.layer_sel];
      bus.layer_g = src_g[bus.layer_sel];
      bus.layer_b = src_b[bus.layer_sel];
      bus.layer_a = src_a[bus.layer_sel];
      pend = 1;
    end else if (pend) begin
      pend = 0;
    end else begin
      bus.layer_r = D'($urandom);
      bus.layer_g = D'($urandom);
      bus.layer_b = D'($urandom);
      bus.layer_a = 1'($urandom);
    end
  end

  function automatic pix_t cur_out();
    return {bus.out_r, bus.out_g, bus.out_b, bus.out_a};
  endfunction

  task automatic set_layer(input int i, input logic [D-1:0] r, g, b, input logic a);
    src_r[i] = r; src_g[i] = g; src_b[i] = b; src_a[i] = a;
  endtask

  task automatic clear_layers();
    for (int i = 0; i < NL; i++) set_layer(i, D'($urandom), D'($urandom), D'($urandom), 1'b0);
  endtask

  task automatic check_idle_reset(input string name);
    checks++;
    if ({bus.req_ready, bus.out_valid, bus.layer_req, bus.layer_sel, cur_out()} !== {1'b1, 1'b0, 1'b0, 2'd0, 13'd0}) begin
      errors++;
      $display("FAIL %s: rdy=%b vld=%b lreq=%b sel=%0d out=%h want rdy=1 vld=0 lreq=0 sel=0 out=0",
               name, bus.req_ready, bus.out_valid, bus.layer_req, bus.layer_sel, cur_out());
    end
  endtask

  // expected pixel, and index of the last layer the scheduler should fetch
  task automatic push_expect(input logic [D-1:0] br, bgv, bb, output int last);
    pix_t e;
    int top;
    e = {br, bgv, bb, 1'b0};
    top = -1;
    for (int i = NL - 1; i >= 0; i--)
      if (src_a[i] && top < 0) begin
        top = i;
        e = {src_r[i], src_g[i], src_b[i], 1'b1};
      end
`ifdef LAYER_SCHED_EARLY_EXIT_EN
    last = top < 0 ? 0 : top;
`else
    last = 0;
`endif
    sb.push_back(e);
  endtask

  task automatic start_req(input logic [D-1:0] br, bgv, bb);
    sel_log.delete();
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_idle: got %b want 1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.bg_r = br; bus.bg_g = bgv; bus.bg_b = bb;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.bg_r = D'($urandom); bus.bg_g = D'($urandom); bus.bg_b = D'($urandom);
  endtask

  task automatic do_req(input logic [D-1:0] br, bgv, bb, input int stall);
    int last, n, lat;
    pix_t e, got;
    push_expect(br, bgv, bb, last);
    lat = 2 * (NL - last) + 1;
    start_req(br, bgv, bb);
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL latency: got %0d want %0d", n, lat);
      if (n >= 100) begin
        void'(sb.pop_front());
        return;
      end
    end
    e = sb.pop_front();
    got = cur_out();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL result: got %h want %h", got, e);
    end
    checks++;
    if (sel_log.size() != NL - last) begin
      errors++;
      $display("FAIL fetch_count: got %0d want %0d", sel_log.size(), NL - last);
    end
    for (int i = 0; i < sel_log.size() && i < NL; i++) begin
      checks++;
      if (sel_log[i] != NL - 1 - i) begin
        errors++;
        $display("FAIL fetch_order[%0d]: got %0d want %0d", i, sel_log[i], NL - 1 - i);
      end
    end
    bus.req_valid = 1'b1;
    if (stall > 0) bus.out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.req_ready, cur_out()} !== {1'b1, 1'b0, e}) begin
        errors++;
        $display("FAIL stall: vld=%b rdy=%b out=%h want vld=1 rdy=0 out=%h",
                 bus.out_valid, bus.req_ready, cur_out(), e);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL release_idle: vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid, bus.req_ready);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_reset("post_reset");
  endtask

  task automatic test_transparent();
    clear_layers();
    do_req(4'd1, 4'd2, 4'd3, 0);
  endtask

  task automatic test_opaque_priority();
    clear_layers();
    set_layer(2, 4'hA, 4'hB, 4'hC, 1'b1);
    set_layer(0, 4'd5, 4'd5, 4'd5, 1'b1);
    do_req(4'd7, 4'd8, 4'd9, 0);
  endtask

  task automatic test_top_opaque();
    clear_layers();
    set_layer(3, 4'hE, 4'h1, 4'h6, 1'b1);
    set_layer(1, 4'h2, 4'h3, 4'h4, 1'b1);
    do_req(4'd0, 4'd0, 4'd0, 0);
  endtask

  task automatic test_backpressure();
    clear_layers();
    set_layer(1, 4'h9, 4'h0, 4'hF, 1'b1);
    do_req(4'd3, 4'd3, 4'd3, 10);
  endtask

  task automatic test_reset_midflight();
    int n, last;
    clear_layers();
    set_layer(0, 4'hC, 4'hD, 4'hE, 1'b1);
    push_expect(4'd6, 4'd6, 4'd6, last);
    start_req(4'd6, 4'd6, 4'd6);
    n = 0;
    while (!(bus.layer_sel == 1 && !bus.layer_req && !bus.req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL reach_capture1: got timeout want capture of layer 1");
    end
    void'(sb.pop_front());
    bus.out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle_reset("midflight_reset");
    for (int i = 0; i < 2 * NL + 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abandoned_out_valid: got %b want 0", bus.out_valid);
      end
    end
    do_req(4'd6, 4'd6, 4'd6, 0);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NL; i++)
        set_layer(i, D'($urandom), D'($urandom), D'($urandom), 1'($urandom_range(0, 3) == 0));
      do_req(D'($urandom), D'($urandom), D'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.bg_r = '0; bus.bg_g = '0; bus.bg_b = '0;
    clear_layers();
    @(negedge clk);
    test_reset();
    test_transparent();
    test_opaque_priority();
    test_top_opaque();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
